// File: rtl/bcs_pkg.sv
// ============================================================================
// Module   : bcs_pkg
// Purpose  : Shared constants and state type for the bubble-collapse packer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bcs_pkg;

    localparam int LINE_SIZE   = 32;
    localparam int PSUM_WIDTH  = 6;
    localparam int TOTAL_WIDTH = 7;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TAIL = 1'b1
    } bcs_state_e;

endpackage

`default_nettype wire

// File: rtl/bcs_psum_gen.sv
// ============================================================================
// Module   : bcs_psum_gen
// Purpose  : Keep-mask to per-lane shift distance (exclusive zero prefix count)
//            and kept-word popcount. Purely combinational.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcs_psum_gen
    import bcs_pkg::*;
(
    input  logic [LINE_SIZE-1:0]            i_mask,
    output logic [LINE_SIZE*PSUM_WIDTH-1:0] o_psum,
    output logic [PSUM_WIDTH-1:0]           o_count
);

    logic [PSUM_WIDTH-1:0] w_zeros;

    // Lane i shifts down by the number of bubbles strictly below it.
    always_comb begin
        w_zeros = '0;
        o_count = '0;
        o_psum  = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            o_psum[i*PSUM_WIDTH +: PSUM_WIDTH] = w_zeros;
            w_zeros = w_zeros + {{(PSUM_WIDTH-1){1'b0}}, ~i_mask[i]};
            o_count = o_count + {{(PSUM_WIDTH-1){1'b0}}, i_mask[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcs_pack_ctrl.sv
// ============================================================================
// Module   : bcs_pack_ctrl
// Purpose  : Sequencer for the 32-lane bubble-collapsing shifter; packs the
//            collapsed words of successive lines into dense output lines.
//            Optional macro BCS_STAT_EN adds stat_lines / stat_bubbles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcs_pack_ctrl
    import bcs_pkg::*;
#(
    parameter int WORD_WIDTH    = 8,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 3
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]               in_line,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] in_mt,
    input  logic [LINE_SIZE-1:0]                          in_mask,
    input  logic                                          in_last,
    output logic [LINE_SIZE*PSUM_WIDTH-1:0]               sh_psum,
    output logic [LINE_SIZE-1:0]                          sh_mask,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]               sh_lifm_line,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] sh_mt_line,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]               sh_lifm_comp,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]               out_line,
    output logic [PSUM_WIDTH-1:0]                         out_cnt,
    output logic                                          out_last
`ifdef BCS_STAT_EN
    ,
    output logic [31:0]                                   stat_lines,
    output logic [31:0]                                   stat_bubbles
`endif
);

    localparam int LW  = LINE_SIZE * WORD_WIDTH;
    localparam int MTW = LINE_SIZE * DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int PSW = LINE_SIZE * PSUM_WIDTH;

    // ------------------------------------------------------------------------
    // Stage A
    // ------------------------------------------------------------------------
    logic                   r_a_valid;
    logic                   r_a_last;
    logic [PSUM_WIDTH-1:0]  r_a_k;
    logic [PSW-1:0]         r_a_psum;
    logic [LINE_SIZE-1:0]   r_a_mask;
    logic [LW-1:0]          r_a_line;
    logic [MTW-1:0]         r_a_mt;

    logic [PSW-1:0]         w_in_psum;
    logic [PSUM_WIDTH-1:0]  w_in_k;
    logic                   w_in_fire;
    logic                   w_a_consume;

    bcs_psum_gen u_psum_gen (
        .i_mask  (in_mask),
        .o_psum  (w_in_psum),
        .o_count (w_in_k)
    );

    assign in_ready  = !reset && (!r_a_valid || w_a_consume);
    assign w_in_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_a_k     <= '0;
            r_a_psum  <= '0;
            r_a_mask  <= '0;
            r_a_line  <= '0;
            r_a_mt    <= '0;
        end else if (w_in_fire) begin
            r_a_valid <= 1'b1;
            r_a_last  <= in_last;
            r_a_k     <= w_in_k;
            r_a_psum  <= w_in_psum;
            r_a_mask  <= in_mask;
            r_a_line  <= in_line;
            r_a_mt    <= in_mt;
        end else if (w_a_consume) begin
            r_a_valid <= 1'b0;
        end
    end

    assign sh_psum      = r_a_psum;
    assign sh_mask      = r_a_mask;
    assign sh_lifm_line = r_a_line;
    assign sh_mt_line   = r_a_mt;

    // ------------------------------------------------------------------------
    // Accumulator concatenation
    // ------------------------------------------------------------------------
    logic [LW-1:0]          r_acc;
    logic [PSUM_WIDTH-1:0]  r_acc_cnt;
    logic [LW-1:0]          w_comp_m;
    logic [2*LW-1:0]        w_cat;
    logic [31:0]            w_shamt;
    logic [TOTAL_WIDTH-1:0] w_total;
    logic [PSUM_WIDTH-1:0]  w_rem;
    logic                   w_full;

    // Lanes at or above k are forced to zero so unused accumulator lanes stay clean.
    always_comb begin
        w_comp_m = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            if (PSUM_WIDTH'(i) < r_a_k)
                w_comp_m[i*WORD_WIDTH +: WORD_WIDTH] = sh_lifm_comp[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end

    assign w_shamt = 32'(r_acc_cnt) * 32'(WORD_WIDTH);
    assign w_cat   = ({{LW{1'b0}}, w_comp_m} << w_shamt) | {{LW{1'b0}}, r_acc};
    assign w_total = {1'b0, r_acc_cnt} + {1'b0, r_a_k};
    assign w_full  = (w_total >= TOTAL_WIDTH'(LINE_SIZE));
    assign w_rem   = PSUM_WIDTH'(w_total - TOTAL_WIDTH'(LINE_SIZE));

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    bcs_state_e             r_state;
    bcs_state_e             w_state_nxt;
    logic                   w_out_free;

    logic                   w_emit;
    logic [LW-1:0]          w_emit_line;
    logic [PSUM_WIDTH-1:0]  w_emit_cnt;
    logic                   w_emit_last;
    logic                   w_acc_load;
    logic [LW-1:0]          w_acc_nxt;
    logic [PSUM_WIDTH-1:0]  w_acc_cnt_nxt;

    assign w_out_free  = !out_valid || out_ready;
    assign w_a_consume = r_a_valid && (r_state == RUN) && w_out_free;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_a_consume && r_a_last && w_full && (w_rem != '0))
                    w_state_nxt = TAIL;
            end
            TAIL: begin
                if (w_out_free)
                    w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_emit        = 1'b0;
        w_emit_line   = w_cat[LW-1:0];
        w_emit_cnt    = PSUM_WIDTH'(LINE_SIZE);
        w_emit_last   = 1'b0;
        w_acc_load    = 1'b0;
        w_acc_nxt     = r_acc;
        w_acc_cnt_nxt = r_acc_cnt;
        case (r_state)
            RUN: begin
                if (w_a_consume) begin
                    w_acc_load = 1'b1;
                    if (w_full) begin
                        w_emit        = 1'b1;
                        w_emit_last   = r_a_last && (w_rem == '0);
                        w_acc_nxt     = w_cat[2*LW-1:LW];
                        w_acc_cnt_nxt = w_rem;
                    end else if (r_a_last) begin
                        w_emit        = 1'b1;
                        w_emit_cnt    = w_total[PSUM_WIDTH-1:0];
                        w_emit_last   = 1'b1;
                        w_acc_nxt     = '0;
                        w_acc_cnt_nxt = '0;
                    end else begin
                        w_acc_nxt     = w_cat[LW-1:0];
                        w_acc_cnt_nxt = w_total[PSUM_WIDTH-1:0];
                    end
                end
            end
            TAIL: begin
                if (w_out_free) begin
                    w_emit        = 1'b1;
                    w_emit_line   = r_acc;
                    w_emit_cnt    = r_acc_cnt;
                    w_emit_last   = 1'b1;
                    w_acc_load    = 1'b1;
                    w_acc_nxt     = '0;
                    w_acc_cnt_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_acc_load) begin
            r_acc     <= w_acc_nxt;
            r_acc_cnt <= w_acc_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Output register: holds while stalled
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_line  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
        end else if (w_emit) begin
            out_valid <= 1'b1;
            out_line  <= w_emit_line;
            out_cnt   <= w_emit_cnt;
            out_last  <= w_emit_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BCS_STAT_EN
    logic [31:0] r_stat_lines;
    logic [31:0] r_stat_bubbles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_lines   <= '0;
            r_stat_bubbles <= '0;
        end else if (w_in_fire) begin
            r_stat_lines   <= r_stat_lines + 32'd1;
            r_stat_bubbles <= r_stat_bubbles + (32'(LINE_SIZE) - 32'(w_in_k));
        end
    end

    assign stat_lines   = r_stat_lines;
    assign stat_bubbles = r_stat_bubbles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcs_pack_ctrl.sv
// ============================================================================
// Module   : tb_bcs_pack_ctrl
// Purpose  : Self-checking bench for bcs_pack_ctrl with a behavioural shifter
//            and a word-queue packing reference. Honours BCS_STAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcs_pack_ctrl;

    localparam int WW  = 8;
    localparam int LW  = 32 * WW;
    localparam int MTW = 32 * 7 * 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [LW-1:0]   in_line;
    logic [MTW-1:0]  in_mt;
    logic [31:0]     in_mask;
    logic            in_last;
    logic [191:0]    sh_psum;
    logic [31:0]     sh_mask;
    logic [LW-1:0]   sh_lifm_line;
    logic [MTW-1:0]  sh_mt_line;
    logic [LW-1:0]   sh_lifm_comp;
    logic            out_valid;
    logic            out_ready;
    logic [LW-1:0]   out_line;
    logic [5:0]      out_cnt;
    logic            out_last;
`ifdef BCS_STAT_EN
    logic [31:0]     stat_lines;
    logic [31:0]     stat_bubbles;
`endif

    always #5 clk = ~clk;

    bcs_pack_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_line      (in_line),
        .in_mt        (in_mt),
        .in_mask      (in_mask),
        .in_last      (in_last),
        .sh_psum      (sh_psum),
        .sh_mask      (sh_mask),
        .sh_lifm_line (sh_lifm_line),
        .sh_mt_line   (sh_mt_line),
        .sh_lifm_comp (sh_lifm_comp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_line     (out_line),
        .out_cnt      (out_cnt),
        .out_last     (out_last)
`ifdef BCS_STAT_EN
        ,
        .stat_lines   (stat_lines),
        .stat_bubbles (stat_bubbles)
`endif
    );

    // Behavioural bubble-collapsing shifter
    always_comb begin
        int j;
        j = 0;
        sh_lifm_comp = '0;
        for (int i = 0; i < 32; i++) begin
            if (sh_mask[i]) begin
                sh_lifm_comp[j*WW +: WW] = sh_lifm_line[i*WW +: WW];
                j++;
            end
        end
    end

    typedef struct packed {
        logic [LW-1:0] line;
        logic [5:0]    cnt;
        logic          last;
    } exp_t;

    typedef struct {
        logic [31:0] mask;
        logic        last;
        logic [5:0]  p1;
        logic [5:0]  p3;
        logic [5:0]  p31;
    } vec_t;

    exp_t        exp_q[$];
    logic [7:0]  mq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          s_lines = 0;
    int          s_bub   = 0;
    logic [LW-1:0]  last_line;
    logic [MTW-1:0] last_mt;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packer: a plain word FIFO cut into 32-word lines
    task automatic model_accept(input logic [LW-1:0] line, input logic [31:0] m, input logic l);
        int   emitted;
        int   n;
        exp_t e;
        emitted = 0;
        for (int i = 0; i < 32; i++)
            if (m[i]) mq.push_back(line[i*WW +: WW]);
        while (mq.size() >= 32) begin
            e.line = '0;
            for (int i = 0; i < 32; i++) e.line[i*WW +: WW] = mq.pop_front();
            e.cnt  = 6'd32;
            e.last = l && (mq.size() == 0);
            exp_q.push_back(e);
            emitted++;
        end
        if (l && (mq.size() > 0 || emitted == 0)) begin
            n      = mq.size();
            e.line = '0;
            e.cnt  = 6'(n);
            for (int i = 0; i < n; i++) e.line[i*WW +: WW] = mq.pop_front();
            e.last = 1'b1;
            exp_q.push_back(e);
        end
        s_lines++;
        s_bub += 32 - $countones(m);
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [31:0] m, input logic l);
        int waited;
        waited = 0;
        for (int i = 0; i < 32; i++) in_line[i*WW +: WW] = 8'($urandom_range(1, 255));
        for (int i = 0; i < MTW/32; i++) in_mt[i*32 +: 32] = $urandom;
        in_mask   = m;
        in_last   = l;
        in_valid  = 1'b1;
        last_line = in_line;
        last_mt   = in_mt;
        #1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles, required 1", waited);
        end else begin
            model_accept(in_line, m, l);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        repeat (2) @(negedge clk);
        chk("drain_queue_empty", LW'(exp_q.size()), LW'(0));
    endtask

    // Output monitor / scoreboard
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got cnt=%0d last=%0b, expected no output", out_cnt, out_last);
            end else begin
                e = exp_q.pop_front();
                chk("out_line", out_line, e.line);
                chk("out_cnt", LW'(out_cnt), LW'(e.cnt));
                chk("out_last", LW'(out_last), LW'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'hAAAA_AAAA, 1'b0, 6'd1, 6'd2, 6'd16};
        vecs[1] = '{32'hAAAA_AAAA, 1'b0, 6'd1, 6'd2, 6'd16};
        vecs[2] = '{32'hAAAA_AAAA, 1'b1, 6'd1, 6'd2, 6'd16};
        vecs[3] = '{32'h0000_FFFF, 1'b0, 6'd0, 6'd0, 6'd15};
        vecs[4] = '{32'h0000_FFFF, 1'b1, 6'd0, 6'd0, 6'd15};
        vecs[5] = '{32'h5555_5555, 1'b1, 6'd0, 6'd1, 6'd15};
        vecs[6] = '{32'h8000_0001, 1'b1, 6'd0, 6'd2, 6'd30};
        vecs[7] = '{32'h0000_0000, 1'b0, 6'd1, 6'd3, 6'd31};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_line   = '0;
        in_mt     = '0;
        in_mask   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", LW'(in_ready), LW'(0));
        chk("reset_out_valid", LW'(out_valid), LW'(0));
        chk("reset_out_line", out_line, LW'(0));
        chk("reset_out_cnt", LW'(out_cnt), LW'(0));
        chk("reset_sh_psum", LW'(sh_psum), LW'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", LW'(in_ready), LW'(1));

        // Full line: emitted one cycle after stage A, out_cnt=32, not last
        @(negedge clk);
        send(32'hFFFF_FFFF, 1'b0);
        #1;
        chk("lat_out_valid_early", LW'(out_valid), LW'(0));
        chk("full_sh_psum", LW'(sh_psum), LW'(0));
        @(negedge clk);
        #1;
        chk("lat_out_valid", LW'(out_valid), LW'(1));
        wait_drain();

        // Table of psum vectors flowing through the packer
        for (int v = 0; v < 8; v++) begin
            send(vecs[v].mask, vecs[v].last);
            #1;
            chk($sformatf("v%0d_sh_mask", v), LW'(sh_mask), LW'(vecs[v].mask));
            chk($sformatf("v%0d_psum1", v), LW'(sh_psum[1*6 +: 6]), LW'(vecs[v].p1));
            chk($sformatf("v%0d_psum3", v), LW'(sh_psum[3*6 +: 6]), LW'(vecs[v].p3));
            chk($sformatf("v%0d_psum31", v), LW'(sh_psum[31*6 +: 6]), LW'(vecs[v].p31));
            chk($sformatf("v%0d_psum0", v), LW'(sh_psum[5:0]), LW'(0));
            chk($sformatf("v%0d_sh_line", v), sh_lifm_line, last_line);
            n_tests++;
            if (sh_mt_line !== last_mt) begin
                n_fail++;
                $display("FAIL v%0d_sh_mt: forwarded mapping table differs from input", v);
            end
        end
        // close the frame left open by the last table entry
        send(32'h0000_0000, 1'b1);
        wait_drain();

        // Streaming with a 5-cycle downstream stall; last line drives TAIL
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    if (i < 6)       send(32'hFFFF_FFFF, 1'b0);
                    else if (i == 6) send(32'hFFFF_00FF, 1'b0);
                    else             send(32'h0FF0_FFFF, 1'b1);
                end
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                chk("stall_in_ready", LW'(in_ready), LW'(0));
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-frame with 20 words accumulated
        send(32'h000F_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_in_ready", LW'(in_ready), LW'(0));
        chk("midrst_out_valid", LW'(out_valid), LW'(0));
        chk("midrst_out_cnt", LW'(out_cnt), LW'(0));
        chk("midrst_out_line", out_line, LW'(0));
        chk("midrst_out_last", LW'(out_last), LW'(0));
        chk("midrst_sh_mask", LW'(sh_mask), LW'(0));
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        exp_q.delete();
        s_lines = 0;
        s_bub   = 0;
        @(negedge clk);

        // Empty last line: cnt 0, last 1, zero line
        send(32'h0000_0000, 1'b1);
        wait_drain();
`ifdef BCS_STAT_EN
        chk("stat_lines", LW'(stat_lines), LW'(s_lines));
        chk("stat_bubbles", LW'(stat_bubbles), LW'(s_bub));
`endif

        // New frame after reset carries only fresh words
        send(32'hFFFF_FFFF, 1'b1);
        wait_drain();
`ifdef BCS_STAT_EN
        chk("stat_lines_2", LW'(stat_lines), LW'(s_lines));
        chk("stat_bubbles_2", LW'(stat_bubbles), LW'(s_bub));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
